conway_vga_scan: RTL and testbench

Display-side reader for the Conway cell grid. The update engine writes cell states into a cell buffer; this block reads that buffer back and turns it into a 640x480 @ 60 Hz VGA raster. Each cell is drawn as a square block of pixels. The block also tells the update engine when vertical blanking starts, so the engine can write or swap generations without tearing.

---
 rtl/conway_vga_scan.sv | 151 +++++++++++++++
 tb/tb_conway_vga_scan.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_vga_scan.sv
// conway_vga_scan
// Reads the Conway cell buffer back and renders it as a 640x480 @ 60 Hz VGA
// raster. Each cell is a (1<<CELL_SHIFT)-pixel square. frame_start marks the
// start of vertical blanking so the update engine can swap generations
// without tearing.
//
// Ports:
//   board_clk    100 MHz clock; the pixel rate is board_clk/4
//   Reset        asynchronous, active-high
//   cell_addr    buffer read address, row*GRID_W + col
//   cell_rd      read strobe, high while the addressed pixel is visible
//   cell_data    cell state from the buffer (1 = live), sampled on div 1->2
//   hsync/vsync  active-low syncs, registered alongside the colour
//   vga_r/g/b    colour, 3/3/2 bits
//   vblank       high while vcnt >= 480
//   frame_start  one-clock pulse when vcnt becomes 480
//
// Build option: define GRID_LINES_EN to draw gray grid lines on dead cells.

module conway_vga_scan #(
  parameter int         CELL_SHIFT = 3,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] LIVE_RGB   = 8'b000_111_00
) (
  input  logic              board_clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              cell_rd,
  input  logic              cell_data,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        vga_r,
  output logic [2:0]        vga_g,
  output logic [1:0]        vga_b,
  output logic              vblank,
  output logic              frame_start
);

  localparam int                GRID_W   = 640 >> CELL_SHIFT;
  localparam logic [ADDR_W-1:0] GRID_W_V = ADDR_W'(GRID_W);
`ifdef GRID_LINES_EN
  localparam logic [9:0]        CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
  localparam logic [7:0]        GRID_RGB  = 8'b010_010_01;
`endif

  logic [1:0]        div_q, div_d;
  logic [9:0]        hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
  logic              cell_rd_q, cell_rd_d;
  logic              cell_q, cell_d;
  logic [7:0]        rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              vblank_q, vblank_d;
  logic              frame_start_q, frame_start_d;

  logic       pix_ce, h_wrap, vis_cur, vis_next;
  logic [9:0] h_next, v_next;
  logic [7:0] pix_rgb;

  // row*GRID_W + col; GRID_W is a constant, so the product is a sum of
  // shifted copies of row, one per set bit of GRID_W.
  function automatic logic [ADDR_W-1:0] cell_index(input logic [9:0] h,
                                                   input logic [9:0] v);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] acc;
    row = ADDR_W'(v >> CELL_SHIFT);
    acc = ADDR_W'(h >> CELL_SHIFT);
    for (int i = 0; i < ADDR_W; i++) begin
      if (GRID_W_V[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

  always_comb begin
    div_d    = div_q + 2'd1;
    pix_ce   = (div_q == 2'd3);
    h_wrap   = (hcnt_q == 10'd799);
    h_next   = h_wrap ? 10'd0 : hcnt_q + 10'd1;
    if (h_wrap) v_next = (vcnt_q == 10'd524) ? 10'd0 : vcnt_q + 10'd1;
    else        v_next = vcnt_q;
    vis_cur  = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
    vis_next = (h_next < 10'd640) && (v_next < 10'd480);

    hcnt_d = pix_ce ? h_next : hcnt_q;
    vcnt_d = pix_ce ? v_next : vcnt_q;

    // Read phase: fetch for the pixel that starts at this edge; the address
    // holds through blanking so the buffer sees no spurious activity.
    cell_addr_d = cell_addr_q;
    if (pix_ce && vis_next) cell_addr_d = cell_index(h_next, v_next);
    cell_rd_d = pix_ce ? vis_next : cell_rd_q;

    // Only the div 1->2 edge listens to the buffer.
    cell_d = (div_q == 2'd1) ? cell_data : cell_q;

    pix_rgb = 8'd0;
    if (vis_cur && cell_q) pix_rgb = LIVE_RGB;
`ifdef GRID_LINES_EN
    else if (vis_cur && (((hcnt_q & CELL_MASK) == 10'd0) ||
                         ((vcnt_q & CELL_MASK) == 10'd0)))
      pix_rgb = GRID_RGB;
`endif

    // Output phase: colour and sync for the pixel that ends at this edge.
    rgb_d   = pix_ce ? pix_rgb : rgb_q;
    hsync_d = pix_ce ? !((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751)) : hsync_q;
    vsync_d = pix_ce ? !((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491)) : vsync_q;

    vblank_d      = pix_ce ? (v_next >= 10'd480) : vblank_q;
    frame_start_d = pix_ce && h_wrap && (vcnt_q == 10'd479);
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      div_q         <= 2'd0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      cell_addr_q   <= '0;
      cell_rd_q     <= 1'b0;
      cell_q        <= 1'b0;
      rgb_q         <= 8'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      cell_addr_q   <= cell_addr_d;
      cell_rd_q     <= cell_rd_d;
      cell_q        <= cell_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cell_addr   = cell_addr_q;
  assign cell_rd     = cell_rd_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[7:5];
  assign vga_g       = rgb_q[4:2];
  assign vga_b       = rgb_q[1:0];
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_conway_vga_scan.sv
// Testbench for conway_vga_scan: randomized cell buffer contents checked
// against a pixel-index model of the raster. Reaching the far lines of a frame
// would take over a million clocks, so runs that need them preload the line
// counter while reset is held and then release from there.

module tb_conway_vga_scan;

  localparam logic [7:0] LIVE  = 8'b000_111_00;
  localparam logic [7:0] GRAY  = 8'b010_010_01;
  localparam int         FRAME = 800 * 525;

  logic        board_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [12:0] cell_addr;
  logic        cell_rd;
  logic        cell_data = 1'b0;
  logic        hsync, vsync;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        vblank, frame_start;

  int tests = 0;
  int fails = 0;

  bit       mem [0:4799];
  logic [1:0] ph;

  conway_vga_scan dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .cell_addr   (cell_addr),
    .cell_rd     (cell_rd),
    .cell_data   (cell_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always #5 board_clk = ~board_clk;

  // Buffer model: the read lands one clock after the address settles and is
  // held only through the sampling cycle; every other cycle carries noise.
  always @(posedge board_clk or posedge Reset)
    if (Reset) ph <= 2'd0;
    else       ph <= ph + 2'd1;

  function automatic bit mem_rd(input logic [12:0] a);
    if (int'(a) < 4800) return mem[int'(a)];
    return 1'b0;
  endfunction

  always @(posedge board_clk)
    cell_data <= (ph == 2'd0) ? mem_rd(cell_addr) : 1'($urandom);

  function automatic int hof(input int p); return p % 800; endfunction
  function automatic int vof(input int p); return (p / 800) % 525; endfunction
  function automatic bit vis(input int p); return hof(p) < 640 && vof(p) < 480; endfunction
  function automatic int cidx(input int p); return (vof(p) / 8) * 80 + hof(p) / 8; endfunction

  function automatic logic [7:0] colour(input int p, input bit live);
    if (!vis(p)) return 8'd0;
    if (live) return LIVE;
`ifdef GRID_LINES_EN
    if (hof(p) % 8 == 0 || vof(p) % 8 == 0) return GRAY;
`endif
    return 8'd0;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 4800; i++) begin
      if (mode == 1)      mem[i] = (i == 0);
      else if (mode == 2) mem[i] = ($urandom_range(2) == 0);
      else                mem[i] = 1'b0;
    end
  endtask

  // Release reset with the line counter at start_line and check every clock.
  // t counts clock edges since release; the counters then sit at pixel
  // base + t/4 and the outputs show the pixel before that.
  task automatic run_from(input int start_line, input int ncyc, input string name,
                          output int fs_cnt, output int hs_fall);
    int base, c, o, exp_addr, t_last;
    bit exp_rd, exp_hs, exp_vs, exp_vb, exp_fs, live, prev_hs;
    logic [7:0] exp_rgb;
    base = start_line * 800;
    exp_addr = 0;
    fs_cnt = 0;
    hs_fall = -1;
    prev_hs = 1'b1;
    @(negedge board_clk);
    dut.vcnt_q = 10'(start_line);
    Reset = 1'b0;
    for (int t = 0; t <= ncyc; t++) begin
      if (t > 0) begin
        @(posedge board_clk);
        @(negedge board_clk);
      end
      t_last = t;
      c = (base + t / 4) % FRAME;
      if (t >= 4 && t % 4 == 0 && vis(c)) exp_addr = cidx(c);
      exp_rd = (t >= 4) && vis(c);
      if (t < 4) begin
        exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 8'd0; exp_vb = 1'b0; exp_fs = 1'b0;
      end else begin
        o = (c + FRAME - 1) % FRAME;
        exp_hs = !(hof(o) >= 656 && hof(o) <= 751);
        exp_vs = !(vof(o) >= 490 && vof(o) <= 491);
        // The very first pixel is read from the reset address 0.
        live = (t < 8) ? mem[0] : (vis(o) ? mem[cidx(o)] : 1'b0);
        exp_rgb = colour(o, live);
        exp_vb = vof(c) >= 480;
        exp_fs = (t % 4 == 0) && (c == 480 * 800);
      end

      tests++;
      if ({hsync, vsync, vga_r, vga_g, vga_b} !== {exp_hs, exp_vs, exp_rgb}) begin
        fails++;
        $display("FAIL %s pixel t=%0d got hs=%b vs=%b rgb=%b%b%b want hs=%b vs=%b rgb=%b",
                 name, t, hsync, vsync, vga_r, vga_g, vga_b, exp_hs, exp_vs, exp_rgb);
      end
      tests++;
      if ({vblank, frame_start} !== {exp_vb, exp_fs}) begin
        fails++;
        $display("FAIL %s blank t=%0d got vblank=%b fs=%b want vblank=%b fs=%b",
                 name, t, vblank, frame_start, exp_vb, exp_fs);
      end
      tests++;
      if ({cell_rd, cell_addr} !== {exp_rd, 13'(exp_addr)}) begin
        fails++;
        $display("FAIL %s read t=%0d got rd=%b addr=%0d want rd=%b addr=%0d",
                 name, t, cell_rd, cell_addr, exp_rd, exp_addr);
      end

      if (t >= 4 && t % 4 == 0) begin
        if (c == 479 * 800 + 639) begin
          tests++;
          if (cell_addr !== 13'd4799) begin
            fails++;
            $display("FAIL %s addr_639_479 got %0d want 4799", name, cell_addr);
          end
        end
        if (c == 8 * 800 + 8) begin
          tests++;
          if (cell_addr !== 13'd81) begin
            fails++;
            $display("FAIL %s addr_8_8 got %0d want 81", name, cell_addr);
          end
        end
        if (c == 640 || c == 480 * 800) begin
          tests++;
          if (cell_rd !== 1'b0) begin
            fails++;
            $display("FAIL %s rd_blank c=%0d got %b want 0", name, c, cell_rd);
          end
        end
      end

      if (frame_start === 1'b1) fs_cnt++;
      if (hs_fall < 0 && prev_hs === 1'b1 && hsync === 1'b0) hs_fall = t;
      prev_hs = hsync;
    end
    if (t_last != ncyc) $display("run %s stopped early", name);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge board_clk);
    tests++;
    if ({hsync, vsync, vga_r, vga_g, vga_b} !== {1'b1, 1'b1, 8'd0}) begin
      fails++;
      $display("FAIL reset_pixel got hs=%b vs=%b rgb=%b%b%b want 1 1 0", hsync, vsync, vga_r, vga_g, vga_b);
    end
    tests++;
    if ({vblank, frame_start} !== 2'b00) begin
      fails++;
      $display("FAIL reset_blank got %b%b want 00", vblank, frame_start);
    end
    tests++;
    if ({cell_rd, cell_addr} !== 14'd0) begin
      fails++;
      $display("FAIL reset_read got rd=%b addr=%0d want 0 0", cell_rd, cell_addr);
    end
  endtask

  task automatic test_first_lines();
    int fs, hf;
    fill_mem(1);
    Reset = 1'b1;
    run_from(0, 4 * (8 * 800 + 2) + 2, "first_lines", fs, hf);
    tests++;
    if (hf != 2628) begin
      fails++;
      $display("FAIL hsync_first_fall got %0d want 2628", hf);
    end
    tests++;
    if (fs != 0) begin
      fails++;
      $display("FAIL first_lines_fs got %0d want 0", fs);
    end
  endtask

  task automatic test_frame_edge();
    int fs, hf;
    fill_mem(2);
    Reset = 1'b1;
    run_from(478, 4 * 2400 + 100, "frame_edge", fs, hf);
    tests++;
    if (fs != 1) begin
      fails++;
      $display("FAIL frame_start_count got %0d want 1", fs);
    end
  endtask

  task automatic test_vsync();
    int fs, hf;
    fill_mem(2);
    Reset = 1'b1;
    run_from(489, 4 * 2400 + 100, "vsync", fs, hf);
  endtask

  task automatic test_wrap();
    int fs, hf;
    fill_mem(2);
    Reset = 1'b1;
    run_from(523, 4 * 1600 + 1600, "wrap", fs, hf);
  endtask

  task automatic test_grid();
    int fs, hf;
    fill_mem(0);
    Reset = 1'b1;
    run_from(5, 4 * 20, "grid", fs, hf);
  endtask

  task automatic test_reset_mid();
    int fs, hf;
    fill_mem(2);
    Reset = 1'b1;
    run_from(200, 4 * 300 + 2, "pre_reset", fs, hf);
    #2;
    Reset = 1'b1;
    #1;
    tests++;
    if ({hsync, vsync, vga_r, vga_g, vga_b, vblank, frame_start, cell_rd, cell_addr} !==
        {1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 13'd0}) begin
      fails++;
      $display("FAIL reset_mid got hs=%b vs=%b rgb=%b%b%b vb=%b fs=%b rd=%b addr=%0d",
               hsync, vsync, vga_r, vga_g, vga_b, vblank, frame_start, cell_rd, cell_addr);
    end
    repeat (2) @(negedge board_clk);
    run_from(0, 3000, "post_reset", fs, hf);
  endtask

  initial begin
    test_reset();
    test_first_lines();
    test_frame_edge();
    test_vsync();
    test_wrap();
    test_grid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
